// File: rtl/dmem_router_pkg.sv
// dmem_router_pkg: shared encodings and default address map for the
// 1-to-3 data-memory router (dmem_router3) and its address decoder.
package dmem_router_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH     = 4;
  localparam int unsigned TO_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_T0   = 2'd0,
    SEL_T1   = 2'd1,
    SEL_T2   = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  // Default map: RAM 64 KiB at 0, UART and GPIO 4 KiB windows.
  localparam logic [31:0] DEF_T0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_T0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_T1_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_T1_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_T2_BASE = 32'h2000_0000;
  localparam logic [31:0] DEF_T2_MASK = 32'hFFFF_F000;

endpackage

// File: rtl/dmem_addr_decode3.sv
// dmem_addr_decode3: combinational priority decoder for three targets.
// Ports:
//   addr  - byte address to decode
//   sel_c - selected target (SEL_T0..SEL_T2, SEL_NONE on miss)
//   hit_c - 1 when any target matches
// Overlapping windows resolve t0 > t1 > t2.
module dmem_addr_decode3
  import dmem_router_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  T0_BASE    = DATA_WIDTH'(DEF_T0_BASE),
  parameter logic [DATA_WIDTH-1:0]  T0_MASK    = DATA_WIDTH'(DEF_T0_MASK),
  parameter logic [DATA_WIDTH-1:0]  T1_BASE    = DATA_WIDTH'(DEF_T1_BASE),
  parameter logic [DATA_WIDTH-1:0]  T1_MASK    = DATA_WIDTH'(DEF_T1_MASK),
  parameter logic [DATA_WIDTH-1:0]  T2_BASE    = DATA_WIDTH'(DEF_T2_BASE),
  parameter logic [DATA_WIDTH-1:0]  T2_MASK    = DATA_WIDTH'(DEF_T2_MASK)
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic [1:0]            sel_c,
  output logic                  hit_c
);

  always_comb begin
    sel_c = SEL_NONE;
    hit_c = 1'b0;
    if ((addr & T0_MASK) == T0_BASE) begin
      sel_c = SEL_T0;
      hit_c = 1'b1;
    end else if ((addr & T1_MASK) == T1_BASE) begin
      sel_c = SEL_T1;
      hit_c = 1'b1;
    end else if ((addr & T2_MASK) == T2_BASE) begin
      sel_c = SEL_T2;
      hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_router3.sv
// dmem_router3: routes one core load/store to RAM (t0), UART (t1) or
// GPIO (t2) with a valid/ready issue phase and an rvalid completion,
// then returns a one-cycle response. One transaction outstanding.
// Ports:
//   clk, resetn              - clock, synchronous active-low reset
//   req_*                    - core request (valid/ready, we, addr, wdata, wstrb)
//   resp_valid/rdata/err     - one-cycle response; rdata/err held until next
//   tN_valid/ready           - target N request handshake
//   tN_we/addr/wdata/wstrb   - registered request fields (addr is the offset)
//   tN_rvalid/rdata          - target N completion and read data
// Optional: define ROUTER_TIMEOUT_EN to bound ISSUE/WAIT by TIMEOUT_CYCLES.
module dmem_router3
  import dmem_router_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  T0_BASE        = DATA_WIDTH'(DEF_T0_BASE),
  parameter logic [DATA_WIDTH-1:0]  T0_MASK        = DATA_WIDTH'(DEF_T0_MASK),
  parameter logic [DATA_WIDTH-1:0]  T1_BASE        = DATA_WIDTH'(DEF_T1_BASE),
  parameter logic [DATA_WIDTH-1:0]  T1_MASK        = DATA_WIDTH'(DEF_T1_MASK),
  parameter logic [DATA_WIDTH-1:0]  T2_BASE        = DATA_WIDTH'(DEF_T2_BASE),
  parameter logic [DATA_WIDTH-1:0]  T2_MASK        = DATA_WIDTH'(DEF_T2_MASK),
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  t0_valid,
  input  logic                  t0_ready,
  output logic                  t0_we,
  output logic [DATA_WIDTH-1:0] t0_addr,
  output logic [DATA_WIDTH-1:0] t0_wdata,
  output logic [STRB_WIDTH-1:0] t0_wstrb,
  input  logic                  t0_rvalid,
  input  logic [DATA_WIDTH-1:0] t0_rdata,
  output logic                  t1_valid,
  input  logic                  t1_ready,
  output logic                  t1_we,
  output logic [DATA_WIDTH-1:0] t1_addr,
  output logic [DATA_WIDTH-1:0] t1_wdata,
  output logic [STRB_WIDTH-1:0] t1_wstrb,
  input  logic                  t1_rvalid,
  input  logic [DATA_WIDTH-1:0] t1_rdata,
  output logic                  t2_valid,
  input  logic                  t2_ready,
  output logic                  t2_we,
  output logic [DATA_WIDTH-1:0] t2_addr,
  output logic [DATA_WIDTH-1:0] t2_wdata,
  output logic [STRB_WIDTH-1:0] t2_wstrb,
  input  logic                  t2_rvalid,
  input  logic [DATA_WIDTH-1:0] t2_rdata
);

  // Elaboration-time sanity check on the timeout limit (16-bit counter).
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("dmem_router3: TIMEOUT_CYCLES out of range");
  end

  state_t                state, state_n;
  sel_t                  sel_q, sel_n;
  logic [1:0]            dec_sel_c;
  logic                  dec_hit_c;
  logic                  accept_c;
  logic                  to_hit_c;
  logic                  sel_ready_c, sel_rvalid_c;
  logic [DATA_WIDTH-1:0] sel_rdata_c;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                  err_n;

  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] off0_q, off1_q, off2_q;
  logic [2:0]            tvalid_q;

  dmem_addr_decode3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .T0_BASE    (T0_BASE),
    .T0_MASK    (T0_MASK),
    .T1_BASE    (T1_BASE),
    .T1_MASK    (T1_MASK),
    .T2_BASE    (T2_BASE),
    .T2_MASK    (T2_MASK)
  ) u_decode (
    .addr  (req_addr),
    .sel_c (dec_sel_c),
    .hit_c (dec_hit_c)
  );

  // Handshake/completion of the currently selected target only.
  always_comb begin
    sel_ready_c  = 1'b0;
    sel_rvalid_c = 1'b0;
    sel_rdata_c  = '0;
    case (sel_q)
      SEL_T0: begin sel_ready_c = t0_ready; sel_rvalid_c = t0_rvalid; sel_rdata_c = t0_rdata; end
      SEL_T1: begin sel_ready_c = t1_ready; sel_rvalid_c = t1_rvalid; sel_rdata_c = t1_rdata; end
      SEL_T2: begin sel_ready_c = t2_ready; sel_rvalid_c = t2_rvalid; sel_rdata_c = t2_rdata; end
      default: ;
    endcase
  end

`ifdef ROUTER_TIMEOUT_EN
  logic [TO_CNT_WIDTH-1:0] to_cnt;

  // Cleared on entry to ISSUE, counts every ISSUE/WAIT cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state != ISSUE && state_n == ISSUE) begin
      to_cnt <= '0;
    end else if (state == ISSUE || state == WAIT) begin
      to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
    end
  end

  assign to_hit_c = (to_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit_c = 1'b0;
`endif

  // Next-state and next response values.
  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    rdata_n  = resp_rdata;
    err_n    = resp_err;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          sel_n    = sel_t'(dec_sel_c);
          if (dec_hit_c) begin
            state_n = ISSUE;
          end else begin
            state_n = RESP;
            rdata_n = '0;
            err_n   = 1'b1;
          end
        end
      end
      ISSUE: begin
        // A same-cycle rvalid is ignored here; the target holds it into WAIT.
        if (to_hit_c) begin
          state_n = RESP;
          rdata_n = '0;
          err_n   = 1'b1;
        end else if (sel_ready_c) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sel_rvalid_c) begin
          state_n = RESP;
          rdata_n = we_q ? '0 : sel_rdata_c;
          err_n   = 1'b0;
        end else if (to_hit_c) begin
          state_n = RESP;
          rdata_n = '0;
          err_n   = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sel_q <= SEL_NONE;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
    end
  end

  // Registered outputs, derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      tvalid_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      off0_q     <= '0;
      off1_q     <= '0;
      off2_q     <= '0;
    end else begin
      req_ready   <= (state_n == IDLE);
      resp_valid  <= (state_n == RESP);
      resp_rdata  <= rdata_n;
      resp_err    <= err_n;
      tvalid_q[0] <= (state_n == ISSUE) && (sel_n == SEL_T0);
      tvalid_q[1] <= (state_n == ISSUE) && (sel_n == SEL_T1);
      tvalid_q[2] <= (state_n == ISSUE) && (sel_n == SEL_T2);
      if (accept_c) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        off0_q  <= req_addr & ~T0_MASK;
        off1_q  <= req_addr & ~T1_MASK;
        off2_q  <= req_addr & ~T2_MASK;
      end
    end
  end

  assign t0_valid = tvalid_q[0];
  assign t1_valid = tvalid_q[1];
  assign t2_valid = tvalid_q[2];
  assign t0_we    = we_q;
  assign t1_we    = we_q;
  assign t2_we    = we_q;
  assign t0_wdata = wdata_q;
  assign t1_wdata = wdata_q;
  assign t2_wdata = wdata_q;
  assign t0_wstrb = wstrb_q;
  assign t1_wstrb = wstrb_q;
  assign t2_wstrb = wstrb_q;
  assign t0_addr  = off0_q;
  assign t1_addr  = off1_q;
  assign t2_addr  = off2_q;

endmodule

// File: doc/dmem_router3.md
Name: dmem_router3

Overview:
- 1-to-3 data-memory request router; the distribution counterpart to the core's 3-input result select.
- Takes a single load/store request from the RISC-V core's memory stage.
- Decodes the address to one of three targets (RAM, UART, GPIO), issues the request with a valid/ready handshake, and returns that target's response to the core.
- One outstanding transaction; decode misses produce an error response.

Parameters:
- DATA_WIDTH, 32, data/address width.
- T0_BASE, 32'h0000_0000, target 0 (RAM) base.
- T0_MASK, 32'hFFFF_0000, target 0 match mask.
- T1_BASE, 32'h1000_0000, target 1 (UART) base.
- T1_MASK, 32'hFFFF_F000, target 1 match mask.
- T2_BASE, 32'h2000_0000, target 2 (GPIO) base.
- T2_MASK, 32'hFFFF_F000, target 2 match mask.
- TIMEOUT_CYCLES, 256, bus timeout limit; used only with ROUTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  router accepts request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  4  byte enables.
- resp_valid  out  1  single-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  load data.
- resp_err  out  1  decode miss or timeout.
- tN_valid  out  1  target N request (N=0,1,2).
- tN_ready  in  1  target N accepts.
- tN_we  out  1  registered write enable.
- tN_addr  out  DATA_WIDTH  offset, addr & ~TN_MASK.
- tN_wdata  out  DATA_WIDTH  registered write data.
- tN_wstrb  out  4  registered byte enables.
- tN_rvalid  in  1  target N completion (loads and stores).
- tN_rdata  in  DATA_WIDTH  target N read data.

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is synchronous, active-low.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all tN_valid=0, tN_we/addr/wdata/wstrb=0.
- Address match: hit on (req_addr & TN_MASK) == TN_BASE. Overlapping regions resolve by priority t0 > t1 > t2.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register we/addr/wdata/wstrb and sel.
  - Hit -> ISSUE.
  - Miss -> RESP with err=1, rdata=0.
- ISSUE:
  - t[sel]_valid=1 from registered fields; other targets' valid=0.
  - Fields held stable until t[sel]_ready.
  - On t[sel]_ready -> WAIT; valid drops the next cycle.
- WAIT: on t[sel]_rvalid, capture t[sel]_rdata (0 for stores), err=0 -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. The core cannot stall the response.
- Ignored inputs: req_valid outside IDLE (req_ready=0), any tN_rvalid outside WAIT, and rvalid from a non-selected target.
- Same-cycle ready and rvalid: ready and rvalid asserted together in ISSUE are treated as ready only; the target must hold rvalid until it is seen in WAIT.
- Latency: minimum 3 cycles from accept to resp_valid (accept c0, issue+ready c1, rvalid c2, resp c3). Back-to-back throughput is one transaction per 4 cycles.
- Reset mid-operation: abort to IDLE, all valids low, no response emitted.
- resp_rdata/resp_err hold their value until the next RESP.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined: 16-bit counter cleared on entry to ISSUE and incremented in ISSUE/WAIT. Reaching TIMEOUT_CYCLES-1 -> RESP with err=1, rdata=0, and tN_valid dropped.
- Not defined: no counter; ISSUE/WAIT wait indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package dmem_router_pkg:
  - State encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - Target select encoding (SEL_T0=2'd0, SEL_T1=2'd1, SEL_T2=2'd2, SEL_NONE=2'd3).
  - Default base/mask constants.
- Sub-module dmem_addr_decode3: combinational priority address decoder; outputs sel and hit.

Test Plan:
- Load 0x0000_0010; t0 ready same cycle as valid, rvalid next cycle with 0xDEADBEEF -> t0_addr=0x10, resp_valid at cycle 3, rdata=0xDEADBEEF, err=0.
- Store 0x1000_0004 data 0x41 wstrb 4'b0001; t1 ready after 2 wait cycles -> t1_valid held 3 cycles with stable fields, t1_addr=0x4, resp_valid once, err=0.
- Access 0x3000_0000 -> no tN_valid, resp_valid at cycle 1 after accept, err=1, rdata=0.
- t2 access 0x2000_0008 with a spurious t0_rvalid during WAIT -> t0_rvalid ignored; completes only on t2_rvalid.
- resetn low during WAIT -> next cycle IDLE, req_ready=1, t0..t2_valid=0, no resp_valid.
- ROUTER_TIMEOUT_EN with TIMEOUT_CYCLES=8, t0 never ready -> resp_valid with err=1 after 8 cycles in ISSUE, t0_valid dropped.
